// File: rtl/gpio_mulpop_cop.sv
// gpio_mulpop_cop: bus-mapped shift-add multiplier plus popcount coprocessor with GPIO status and input latch
module gpio_mulpop_cop #(
  parameter int OP_W = 24,
  parameter int RES_W = 32,
  parameter int CNT_W = 16,
  parameter logic [15:0] ADDR_A1 = 16'h037F,
  parameter logic [15:0] ADDR_A2 = 16'h0388,
  parameter logic [15:0] ADDR_W = 16'h0390,
  parameter logic [15:0] ADDR_L = 16'h0398,
  parameter logic [15:0] ADDR_CS = 16'h03A0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp
);
  typedef enum logic [1:0] {IDLE, MUL, POP} state_t;
  state_t state;
  logic [OP_W-1:0] a1, a2, mq;
  logic [2*OP_W-1:0] acc, md, nxt;
  logic [RES_W-1:0] w, pr;
  logic [CNT_W-1:0] cnt;
  logic [5:0] l, pc, idx;
  logic done, valid, ovf, busy, wr_cs, start, abort, unused;
  assign busy = state != IDLE;
  assign wr_cs = swr && saddress == ADDR_CS;
  assign abort = wr_cs && sdata_in[1];
  assign start = wr_cs && sdata_in[0] && !sdata_in[1];
  assign nxt = acc + (mq[0] ? md : '0);
  assign gpio_out = {busy, done, 30'(cnt)};
  assign unused = ^sdata_in;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a1 <= '0;
      a2 <= '0;
      mq <= '0;
      md <= '0;
      acc <= '0;
      w <= '0;
      pr <= '0;
      l <= '0;
      pc <= '0;
      idx <= '0;
      cnt <= '0;
      done <= 1'b0;
      valid <= 1'b0;
      ovf <= 1'b0;
      sdata_out <= '0;
      gpio_in_s_insp <= '0;
    end else begin
      if (gpio_latch) gpio_in_s_insp <= gpio_in;
      if (srd) sdata_out <= saddress == ADDR_W ? 32'(w) :
                           saddress == ADDR_L ? 32'(l) :
                           saddress == ADDR_CS ? {29'b0, busy, valid, done} : 32'b0;
      if (swr && !busy && saddress == ADDR_A1) a1 <= sdata_in[OP_W-1:0];
      if (swr && !busy && saddress == ADDR_A2) a2 <= sdata_in[OP_W-1:0];
      if (abort && busy) begin
        state <= IDLE;
        done <= 1'b0;
        valid <= 1'b0;
        w <= '0;
        l <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state <= MUL;
            md <= (2*OP_W)'(a1);
            mq <= a2;
            acc <= '0;
            idx <= '0;
            pc <= '0;
            w <= '0;
            l <= '0;
            done <= 1'b0;
            valid <= 1'b0;
            cnt <= cnt + 1'b1;
          end
          MUL: begin
            acc <= nxt;
            md <= md << 1;
            mq <= mq >> 1;
            idx <= idx == 6'(OP_W - 1) ? '0 : idx + 1'b1;
            if (idx == 6'(OP_W - 1)) begin
              state <= POP;
              pr <= RES_W'(64'(nxt));
              ovf <= (64'(nxt) >> RES_W) != 64'd0;
            end
          end
          POP: begin
            pc <= pc + 6'(pr[0]);
            pr <= pr >> 1;
            idx <= idx + 1'b1;
            if (idx == 6'(RES_W - 1)) begin
              state <= IDLE;
              w <= RES_W'(64'(acc));
              l <= pc + 6'(pr[0]);
              valid <= !ovf;
              done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gpio_mulpop_cop.sv
// tb_gpio_mulpop_cop: directed checks of the coprocessor register map, timing, abort, reset and counter wrap
module tb_gpio_mulpop_cop;
  localparam logic [15:0] A1 = 16'h037F, A2 = 16'h0388, W = 16'h0390, L = 16'h0398, CS = 16'h03A0;
  localparam logic [15:0] B1 = 16'h1000, B2 = 16'h1008, BW = 16'h1010, BL = 16'h1018, BCS = 16'h1020;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] saddress = '0;
  logic srd = 1'b0, swr = 1'b0, gpio_latch = 1'b0;
  logic [31:0] sdata_in = '0, gpio_in = '0;
  logic [31:0] sdata_out, gpio_out, insp, sdata_out2, gpio_out2, insp2;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  gpio_mulpop_cop u1 (.clk(clk), .reset(reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in), .gpio_latch(gpio_latch),
    .gpio_out(gpio_out), .gpio_in_s_insp(insp));

  gpio_mulpop_cop #(.OP_W(3), .RES_W(8), .CNT_W(4), .ADDR_A1(B1), .ADDR_A2(B2), .ADDR_W(BW),
    .ADDR_L(BL), .ADDR_CS(BCS)) u2 (.clk(clk), .reset(reset), .saddress(saddress), .srd(srd),
    .swr(swr), .sdata_in(sdata_in), .sdata_out(sdata_out2), .gpio_in(gpio_in),
    .gpio_latch(gpio_latch), .gpio_out(gpio_out2), .gpio_in_s_insp(insp2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    saddress = a;
    sdata_in = d;
    swr = 1'b1;
    @(negedge clk);
    swr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    saddress = a;
    srd = 1'b1;
    @(negedge clk);
    srd = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !gpio_out[30]; i++) @(negedge clk);
    chk("done_wait", 32'(gpio_out[30]), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sdata", sdata_out, 32'h0);
    chk("rst_gpio", gpio_out, 32'h0);
    chk("rst_insp", insp, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    rd(CS);
    chk("rst_cs", sdata_out, 32'h0);
    // 3*5 with exact latency: still busy after 55 more edges, done on the 56th
    wr(A1, 32'd3);
    wr(A2, 32'd5);
    wr(CS, 32'd1);
    chk("t1_busy", gpio_out, 32'h8000_0001);
    repeat (55) @(negedge clk);
    chk("t1_not_yet", gpio_out, 32'h8000_0001);
    @(negedge clk);
    chk("t1_gpio", gpio_out, 32'h4000_0001);
    rd(CS);
    chk("t1_cs", sdata_out, 32'h3);
    rd(W);
    chk("t1_w", sdata_out, 32'd15);
    rd(L);
    chk("t1_l", sdata_out, 32'd4);
    wr(W, 32'h1234);
    rd(W);
    chk("w_ro", sdata_out, 32'd15);
    rd(16'h0100);
    chk("unmapped", sdata_out, 32'h0);
    // overflow case, started with a simultaneous CS read that must see the old status
    wr(A1, 32'hFFFFFF);
    wr(A2, 32'hFFFFFF);
    saddress = CS;
    sdata_in = 32'd1;
    swr = 1'b1;
    srd = 1'b1;
    @(negedge clk);
    swr = 1'b0;
    srd = 1'b0;
    chk("rw_same", sdata_out, 32'h3);
    chk("t2_busy", gpio_out, 32'h8000_0002);
    wait_done(80);
    rd(CS);
    chk("t2_cs", sdata_out, 32'h1);
    rd(W);
    chk("t2_w", sdata_out, 32'hFE00_0001);
    rd(L);
    chk("t2_l", sdata_out, 32'd8);
    // writes while busy ignored, then back-to-back start on the done cycle
    wr(A1, 32'd3);
    wr(A2, 32'd5);
    wr(CS, 32'd1);
    repeat (3) @(negedge clk);
    wr(A1, 32'd7);
    wr(CS, 32'd1);
    chk("t3_cnt", gpio_out, 32'h8000_0003);
    wait_done(80);
    chk("t3_done", gpio_out, 32'h4000_0003);
    wr(CS, 32'd1);
    chk("b2b_start", gpio_out, 32'h8000_0004);
    rd(W);
    chk("start_clr_w", sdata_out, 32'h0);
    wait_done(80);
    rd(W);
    chk("t3_w", sdata_out, 32'd15);
    // abort mid-MUL, restart, abort in IDLE
    wr(CS, 32'd1);
    repeat (8) @(negedge clk);
    wr(CS, 32'd2);
    chk("abort_gpio", gpio_out, 32'h0000_0005);
    rd(CS);
    chk("abort_cs", sdata_out, 32'h0);
    rd(W);
    chk("abort_w", sdata_out, 32'h0);
    wr(CS, 32'd1);
    wait_done(80);
    chk("restart_gpio", gpio_out, 32'h4000_0006);
    rd(W);
    chk("restart_w", sdata_out, 32'd15);
    wr(CS, 32'd2);
    chk("abort_idle", gpio_out, 32'h4000_0006);
    gpio_in = 32'hA5A5_5A5A;
    gpio_latch = 1'b1;
    @(negedge clk);
    gpio_latch = 1'b0;
    gpio_in = 32'h0;
    chk("latch", insp, 32'hA5A5_5A5A);
    @(negedge clk);
    chk("latch_hold", insp, 32'hA5A5_5A5A);
    // asynchronous reset during POP
    wr(CS, 32'd1);
    repeat (28) @(negedge clk);
    rd(CS);
    chk("busy_cs", sdata_out, 32'h4);
    #2 reset = 1'b1;
    #1;
    chk("async_sdata", sdata_out, 32'h0);
    chk("async_gpio", gpio_out, 32'h0);
    chk("async_insp", insp, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(CS);
    chk("post_rst_cs", sdata_out, 32'h0);
    wr(A1, 32'd3);
    wr(A2, 32'd5);
    wr(CS, 32'd1);
    chk("post_rst_cnt", gpio_out, 32'h8000_0001);
    wait_done(80);
    rd(W);
    chk("post_rst_w", sdata_out, 32'd15);
    rd(L);
    chk("post_rst_l", sdata_out, 32'd4);
    // narrow instance: 7*7, latency 12 edges, then 4-bit counter wrap
    wr(B1, 32'd7);
    wr(B2, 32'd7);
    wr(BCS, 32'd1);
    chk("n_busy", gpio_out2, 32'h8000_0001);
    repeat (10) @(negedge clk);
    chk("n_not_yet", gpio_out2, 32'h8000_0001);
    @(negedge clk);
    chk("n_done", gpio_out2, 32'h4000_0001);
    rd(BCS);
    chk("n_cs", sdata_out2, 32'h3);
    rd(BW);
    chk("n_w", sdata_out2, 32'd49);
    rd(BL);
    chk("n_l", sdata_out2, 32'd3);
    for (int i = 0; i < 15; i++) begin
      wr(BCS, 32'd1);
      wr(BCS, 32'd2);
      if (i == 13) chk("n_cnt15", gpio_out2, 32'h0000_000F);
    end
    chk("n_wrap", gpio_out2, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
